// File: rtl/score_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : score_controller_if
// Brief    : Award req/ack handshakes and BCD score display bundle.
// Revision : 1.0
// ============================================================================
interface score_controller_if #(
    parameter int SCORE_W = 14
);
    logic               clear_score;
    logic               dig_req;
    logic               dig_ack;
    logic               kill_req;
    logic               kill_ack;
    logic [SCORE_W-1:0] score;
    logic [3:0]         thousands;
    logic [3:0]         hundreds;
    logic [3:0]         tens;
    logic [3:0]         ones;
    logic               digits_valid;
    logic               busy;

    modport master (
        output clear_score, dig_req, kill_req,
        input  dig_ack, kill_ack, score, thousands, hundreds, tens, ones,
               digits_valid, busy
    );

    modport slave (
        input  clear_score, dig_req, kill_req,
        output dig_ack, kill_ack, score, thousands, hundreds, tens, ones,
               digits_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/score_controller.sv
`default_nettype none
// ============================================================================
// Module   : score_controller
// Brief    : Arbitrated saturating score register with double-dabble BCD
//            conversion for the score display.
// Revision : 1.0
// ============================================================================
module score_controller #(
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999,
    parameter int DIG_PTS   = 10,
    parameter int KILL_PTS  = 200
) (
    input  wire logic         Clk,
    input  wire logic         Reset_n,
    score_controller_if.slave bus
);

    localparam int               c_sr_w      = SCORE_W + 16;
    localparam logic [SCORE_W:0] c_max_ext   = MAX_SCORE[SCORE_W:0];
    localparam logic [SCORE_W:0] c_kill_pts  = KILL_PTS[SCORE_W:0];
    localparam logic [SCORE_W:0] c_dig_pts   = DIG_PTS[SCORE_W:0];
    localparam logic [3:0]       c_last_iter = 4'(SCORE_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score;
    logic               r_pending;
    logic               w_pending;
    logic               r_dig_ack;
    logic               w_dig_ack;
    logic               r_kill_ack;
    logic               w_kill_ack;
    logic               r_valid;
    logic               w_valid;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt;
    logic [c_sr_w-1:0]  r_sr;
    logic [c_sr_w-1:0]  w_sr;
    logic [3:0]         r_thousands, r_hundreds, r_tens, r_ones;
    logic [3:0]         w_thousands, w_hundreds, w_tens, w_ones;

    logic [c_sr_w-1:0]  w_adj;
    logic [c_sr_w-1:0]  w_shifted;
    logic [SCORE_W:0]   w_pts;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_sat;

    // Add-3 correction on the BCD nibbles, which sit above the binary field.
    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < 4; i++) begin
            if (r_sr[SCORE_W + 4*i +: 4] >= 4'd5) begin
                w_adj[SCORE_W + 4*i +: 4] = r_sr[SCORE_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = {w_adj[c_sr_w-2:0], 1'b0};

    // Sum is one bit wider than the score so the saturation compare never sees a wrap.
    assign w_pts = bus.kill_req ? c_kill_pts : c_dig_pts;
    assign w_sum = {1'b0, r_score} + w_pts;
    assign w_sat = (w_sum > c_max_ext) ? c_max_ext[SCORE_W-1:0] : w_sum[SCORE_W-1:0];

    always_comb begin
        w_state     = r_state;
        w_score     = r_score;
        w_pending   = r_pending | bus.clear_score;
        w_dig_ack   = 1'b0;
        w_kill_ack  = 1'b0;
        w_valid     = 1'b0;
        w_cnt       = r_cnt;
        w_sr        = r_sr;
        w_thousands = r_thousands;
        w_hundreds  = r_hundreds;
        w_tens      = r_tens;
        w_ones      = r_ones;

        case (r_state)
            IDLE: begin
                if (bus.clear_score || r_pending) begin
                    w_score   = '0;
                    w_pending = 1'b0;
                    w_state   = LOAD;
                end else if (bus.kill_req) begin
                    w_score    = w_sat;
                    w_kill_ack = 1'b1;
                    w_state    = LOAD;
                end else if (bus.dig_req) begin
                    w_score   = w_sat;
                    w_dig_ack = 1'b1;
                    w_state   = LOAD;
                end
            end
            LOAD: begin
                w_sr    = {16'b0, r_score};
                w_cnt   = 4'd0;
                w_state = SHIFT;
            end
            SHIFT: begin
                w_sr  = w_shifted;
                w_cnt = r_cnt + 4'd1;
                if (r_cnt == c_last_iter) begin
                    w_thousands = w_shifted[SCORE_W + 12 +: 4];
                    w_hundreds  = w_shifted[SCORE_W + 8  +: 4];
                    w_tens      = w_shifted[SCORE_W + 4  +: 4];
                    w_ones      = w_shifted[SCORE_W      +: 4];
                    w_valid     = 1'b1;
                    w_state     = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_score     <= '0;
            r_pending   <= 1'b0;
            r_dig_ack   <= 1'b0;
            r_kill_ack  <= 1'b0;
            r_valid     <= 1'b0;
            r_cnt       <= 4'd0;
            r_sr        <= '0;
            r_thousands <= 4'd0;
            r_hundreds  <= 4'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
        end else begin
            r_state     <= w_state;
            r_score     <= w_score;
            r_pending   <= w_pending;
            r_dig_ack   <= w_dig_ack;
            r_kill_ack  <= w_kill_ack;
            r_valid     <= w_valid;
            r_cnt       <= w_cnt;
            r_sr        <= w_sr;
            r_thousands <= w_thousands;
            r_hundreds  <= w_hundreds;
            r_tens      <= w_tens;
            r_ones      <= w_ones;
        end
    end

    assign bus.dig_ack      = r_dig_ack;
    assign bus.kill_ack     = r_kill_ack;
    assign bus.score        = r_score;
    assign bus.thousands    = r_thousands;
    assign bus.hundreds     = r_hundreds;
    assign bus.tens         = r_tens;
    assign bus.ones         = r_ones;
    assign bus.digits_valid = r_valid;
    assign bus.busy         = (r_state != IDLE);

endmodule
`default_nettype wire
